// File: rtl/swivm_uart_tx.sv
// swivm_uart_tx: FIFO-buffered 8N1 UART transmitter for the swivm core console.
// Define SWIVM_UART_PARITY_EN to add an even-parity bit (11-bit frame).
module swivm_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] outbyte,
   input  logic       outbyte_valid,
   output logic       tx,
   output logic       busy,
   output logic       fifo_full,
   output logic       overflow
);

   localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW  = PtrW + 1;
   localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
`ifdef SWIVM_UART_PARITY_EN
      StParity,
`endif
      StStop
   } state_e;

   // Transmit FIFO
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            overflow_q, overflow_d;
   logic            full, empty, push, pop;

   // Serialiser
   state_e           state_q, state_d;
   logic [BaudW-1:0] baud_q, baud_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             tx_q, tx_d;
   logic             last_tick;
`ifdef SWIVM_UART_PARITY_EN
   logic             parity_q, parity_d;
`endif

   assign full  = (count_q == CntW'(FIFO_DEPTH));
   assign empty = (count_q == '0);
   // A write while full is still accepted if the serialiser frees a slot on the same edge.
   assign push  = outbyte_valid && (!full || pop);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | (outbyte_valid & full & ~pop);
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= outbyte;
   end

   assign last_tick = (baud_q == BaudW'(CLKS_PER_BIT - 1));

   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
      pop      = 1'b0;
`ifdef SWIVM_UART_PARITY_EN
      parity_d = parity_q;
`endif
      if (state_q != StIdle) baud_d = last_tick ? '0 : baud_q + BaudW'(1);

      unique case (state_q)
         StIdle: begin
            tx_d = 1'b1;
         end
         StStart: begin
            if (last_tick) begin
               state_d = StData;
               bit_d   = '0;
               tx_d    = shift_q[0];
            end
         end
         StData: begin
            if (last_tick) begin
               if (bit_q == 3'd7) begin
`ifdef SWIVM_UART_PARITY_EN
                  state_d = StParity;
                  tx_d    = parity_q;
`else
                  state_d = StStop;
                  tx_d    = 1'b1;
`endif
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
               end
            end
         end
`ifdef SWIVM_UART_PARITY_EN
         StParity: begin
            if (last_tick) begin
               state_d = StStop;
               tx_d    = 1'b1;
            end
         end
`endif
         StStop: begin
            if (last_tick) begin
               state_d = StIdle;
               tx_d    = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            tx_d    = 1'b1;
         end
      endcase

      // Load the next byte from idle, or straight out of a finished stop bit so frames abut.
      if (!empty && (state_q == StIdle || (state_q == StStop && last_tick))) begin
         pop      = 1'b1;
         shift_d  = mem_q[rd_ptr_q];
         tx_d     = 1'b0;
         state_d  = StStart;
         baud_d   = '0;
`ifdef SWIVM_UART_PARITY_EN
         parity_d = ^mem_q[rd_ptr_q];
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         state_q    <= StIdle;
         baud_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
`ifdef SWIVM_UART_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
`ifdef SWIVM_UART_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

   assign tx        = tx_q;
   assign busy      = (state_q != StIdle) || !empty;
   assign fifo_full = full;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_swivm_uart_tx.sv
// Bench for swivm_uart_tx: per-cycle frame tables plus a serial-decoding scoreboard.
// Frame length follows SWIVM_UART_PARITY_EN.
module tb_swivm_uart_tx;

   localparam int C = 4;
   localparam int D = 16;
`ifdef SWIVM_UART_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] outbyte;
   logic       outbyte_valid;
   logic       tx, busy, fifo_full, overflow;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   swivm_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
      .clk           (clk),
      .reset         (reset),
      .outbyte       (outbyte),
      .outbyte_valid (outbyte_valid),
      .tx            (tx),
      .busy          (busy),
      .fifo_full     (fifo_full),
      .overflow      (overflow)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Line order LSB first: start, data[0..7], (parity), stop.
   function automatic logic [10:0] frame_of(input logic [7:0] d);
`ifdef SWIVM_UART_PARITY_EN
      return {1'b1, ^d, d, 1'b0};
`else
      return {1'b0, 1'b1, d, 1'b0};
`endif
   endfunction

   // Serial monitor: decodes frames off tx and pops the scoreboard.
   logic [10:0] mon_bits;
   int          mon_cnt = 0;
   bit          mon_active = 0;
   logic [7:0]  mon_exp;

   always @(negedge clk) begin
      if (reset) begin
         mon_active = 0;
         mon_cnt    = 0;
      end else if (!mon_active) begin
         if (tx === 1'b0) begin
            mon_active = 1;
            mon_cnt    = 1;
            mon_bits   = '0;
         end
      end else begin
         mon_cnt++;
      end
      if (mon_active && ((mon_cnt - 1) % C) == 1) mon_bits[(mon_cnt - 1) / C] = tx;
      if (mon_active && mon_cnt == FB * C) begin
         mon_active = 0;
         if (exp_q.size() == 0) begin
            check("sb_unexpected_frame", 32'(mon_bits), 32'hffff_ffff);
         end else begin
            mon_exp = exp_q.pop_front();
            check("sb_frame", 32'(mon_bits[FB-1:0]), 32'(frame_of(mon_exp) & 11'((1 << FB) - 1)));
         end
      end
   end

   task automatic wait_idle(input int budget);
      bit done = 0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         if (!busy && !mon_active) done = 1;
      end
      check("wait_idle", 32'(done), 32'd1);
   endtask

   task automatic run_frame(input logic [7:0] d, input logic [10:0] frame);
      @(negedge clk);
      outbyte       = d;
      outbyte_valid = 1'b1;
      exp_q.push_back(d);
      @(negedge clk);
      outbyte_valid = 1'b0;
      check("tx_high_after_capture", 32'(tx), 32'd1);
      check("busy_after_capture", 32'(busy), 32'd1);
      for (int k = 0; k < FB * C; k++) begin
         @(negedge clk);
         check($sformatf("frame_%02h_clk%0d", d, k), 32'(tx), 32'(frame[k / C]));
      end
      @(negedge clk);
      check("idle_tx", 32'(tx), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
   endtask

   typedef struct {
      logic [7:0]  data;
      logic [10:0] frame;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef SWIVM_UART_PARITY_EN
      vecs[0] = '{8'h41, 11'b10010000010};
      vecs[1] = '{8'h0F, 11'b10000011110};
      vecs[2] = '{8'hFF, 11'b10111111110};
      vecs[3] = '{8'hA5, 11'b10101001010};
      vecs[4] = '{8'h07, 11'b11000001110};
      vecs[5] = '{8'h03, 11'b10000000110};
`else
      vecs[0] = '{8'h41, 11'b01010000010};
      vecs[1] = '{8'h0F, 11'b01000011110};
      vecs[2] = '{8'hFF, 11'b01111111110};
      vecs[3] = '{8'hA5, 11'b01101001010};
      vecs[4] = '{8'h07, 11'b01000001110};
      vecs[5] = '{8'h03, 11'b01000000110};
`endif
      reset         = 1'b1;
      outbyte       = '0;
      outbyte_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_full", 32'(fifo_full), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      foreach (vecs[i]) run_frame(vecs[i].data, vecs[i].frame);

      // Back-to-back: two writes on consecutive cycles, frames must abut.
      @(negedge clk);
      outbyte = 8'h55; outbyte_valid = 1'b1; exp_q.push_back(8'h55);
      @(negedge clk);
      outbyte = 8'hAA; exp_q.push_back(8'hAA);
      for (int k = 0; k < 2 * FB * C; k++) begin
         @(negedge clk);
         outbyte_valid = 1'b0;
         if (k < FB * C)
            check("b2b_first", 32'(tx), 32'(frame_of(8'h55) >> (k / C)) & 32'd1);
         else
            check("b2b_second", 32'(tx), 32'(frame_of(8'hAA) >> ((k - FB * C) / C)) & 32'd1);
      end
      @(negedge clk);
      check("b2b_idle_busy", 32'(busy), 32'd0);

      // Overflow: 18 writes from idle, the 18th is dropped.
      wait_idle(200);
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         if (i == 16) check("ovf_not_full_16", 32'(fifo_full), 32'd0);
         if (i == 17) begin
            check("ovf_full_17", 32'(fifo_full), 32'd1);
            check("ovf_clear_17", 32'(overflow), 32'd0);
         end
         outbyte       = 8'(i);
         outbyte_valid = 1'b1;
         if (i <= 16) exp_q.push_back(8'(i));
      end
      @(negedge clk);
      outbyte_valid = 1'b0;
      check("ovf_set_18", 32'(overflow), 32'd1);
      check("ovf_still_full", 32'(fifo_full), 32'd1);
      wait_idle(2000);
      check("ovf_sticky", 32'(overflow), 32'd1);
      check("ovf_queue_drained", 32'(exp_q.size()), 32'd0);

      // Full with a write on the STOP->START pop edge.
      reset = 1'b1;
      @(negedge clk);
      check("rst_clears_overflow", 32'(overflow), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         outbyte       = 8'h80 + 8'(i);
         outbyte_valid = 1'b1;
         exp_q.push_back(8'h80 + 8'(i));
      end
      @(negedge clk);
      outbyte_valid = 1'b0;
      check("fp_full", 32'(fifo_full), 32'd1);
      repeat (24) @(negedge clk);
      check("fp_full_before_pop", 32'(fifo_full), 32'd1);
      outbyte = 8'hC0; outbyte_valid = 1'b1; exp_q.push_back(8'hC0);
      @(negedge clk);
      outbyte_valid = 1'b0;
      check("fp_still_full", 32'(fifo_full), 32'd1);
      check("fp_no_overflow", 32'(overflow), 32'd0);
      wait_idle(2000);
      check("fp_queue_drained", 32'(exp_q.size()), 32'd0);

      // Reset during data bit 3 of 0xFF with a second byte queued.
      @(negedge clk);
      outbyte = 8'hFF; outbyte_valid = 1'b1; exp_q.push_back(8'hFF);
      @(negedge clk);
      outbyte = 8'h33;
      @(negedge clk);
      outbyte_valid = 1'b0;
      repeat (17) @(negedge clk);
      check("mid_data_bit3", 32'(tx), 32'd1);
      check("mid_busy", 32'(busy), 32'd1);
      #1 reset = 1'b1;
      #1;
      check("mid_rst_tx", 32'(tx), 32'd1);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_full", 32'(fifo_full), 32'd0);
      exp_q.delete();
      outbyte = 8'h99; outbyte_valid = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_ignores_valid", 32'(busy), 32'd0);
      outbyte_valid = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      check("no_resume_tx", 32'(tx), 32'd1);
      check("no_resume_busy", 32'(busy), 32'd0);
      run_frame(8'h0F, frame_of(8'h0F));

      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/swivm_uart_tx.md
SWIVM_UART_TX -- requirements
Module: swivm_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clocks per serial bit period (minimum 2).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, byte entries in the transmit FIFO (power of two, minimum 2).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port outbyte  input  8  character from the swivm core.
REQ-006 SHALL have port outbyte_valid  input  1  outbyte is valid this cycle (write strobe).
REQ-007 SHALL have port tx  output  1  serial line; idle high.
REQ-008 SHALL have port busy  output  1  high while a frame is in progress or the FIFO is non-empty.
REQ-009 SHALL have port fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-010 SHALL have port overflow  output  1  sticky flag: a write was dropped.

Function
REQ-011 SHALL capture outbyte into the FIFO on every rising edge where outbyte_valid=1 and the FIFO is not full; writes and pops follow FIFO order.
REQ-012 SHALL drop a write when full with no pop on the same edge, and set overflow=1 on that edge.
REQ-013 SHALL accept a write on an edge with a simultaneous pop, even when full; occupancy is unchanged.
REQ-014 SHALL use a FIFO with no bypass: a byte written into an empty FIFO is visible to the FSM one edge later.
REQ-015 SHALL implement the FSM states IDLE, START, DATA, (PARITY), STOP.
REQ-016 SHALL, in IDLE with the FIFO non-empty, pop the head, load the shift register and enter START on the same edge.
REQ-017 SHALL register tx: 0 in START, data bit in DATA (LSB first, 8 bits), 1 in STOP and IDLE.
REQ-018 SHALL hold each of the START, DATA, PARITY and STOP bits for exactly CLKS_PER_BIT clocks, timed by a baud counter that reloads at each bit boundary.
REQ-019 SHALL, at the end of STOP, pop the next byte and enter START directly if the FIFO is non-empty, otherwise enter IDLE; back-to-back frames have no idle gap.
REQ-020 SHALL drive tx low one edge after the capturing edge when idle: valid sampled at edge E0, tx=0 after E1.
REQ-021 SHALL wrap FIFO pointers modulo FIFO_DEPTH, with an occupancy count of clog2(FIFO_DEPTH)+1 bits.
REQ-022 SHALL keep overflow at 1 until reset.

Reset
REQ-023 SHALL, while reset=1, immediately force tx=1, busy=0, fifo_full=0, overflow=0, FSM=IDLE, FIFO empty, and all counters to 0.
REQ-024 SHALL, on reset asserted mid-frame, abandon the frame with tx high at once and no resumption; the next frame starts cleanly after release.
REQ-025 SHALL ignore outbyte_valid while reset=1.

Configuration
REQ-026 SHALL, with macro SWIVM_UART_PARITY_EN defined, insert a PARITY state between DATA and STOP that transmits the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT clocks, giving an 11-bit frame.
REQ-027 SHALL, without SWIVM_UART_PARITY_EN, have no PARITY state and no parity logic, giving a 10-bit frame.

Verification
REQ-028 SHALL verify single byte (CLKS_PER_BIT=4, no parity): write 0x41 -> tx = 0,1,0,0,0,0,0,1,0,1, each for 4 clocks, first low 1 edge after capture; busy falls after the 40th clock.
REQ-029 SHALL verify back-to-back frames: write 0x55 and 0xAA on consecutive cycles -> two contiguous 40-clock frames, no idle high gap between the stop bit and the second start bit.
REQ-030 SHALL verify overflow (FIFO_DEPTH=16): 18 consecutive writes 0x00..0x11 from idle -> fifo_full=1 after the 17th write, overflow=1 after the 18th; transmitted bytes are 0x00..0x10 with 0x11 absent.
REQ-031 SHALL verify full with simultaneous pop: FIFO full and a write on the STOP->START pop edge -> write accepted, fifo_full stays 1, overflow stays 0.
REQ-032 SHALL verify reset mid-frame: assert reset during DATA bit 3 of 0xFF -> tx=1 in the same cycle, busy=0; after release, write 0x0F -> a clean correct frame.
REQ-033 SHALL verify parity (SWIVM_UART_PARITY_EN defined, CLKS_PER_BIT=4): write 0x07 -> parity bit 1; write 0x03 -> parity bit 0; each frame is 44 clocks.
